// File: rtl/gol_pkg.sv
// gol_pkg: shared state encoding, glider seed rows and neighbour counting for the Game of Life engine.
package gol_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, SWAP} state_e;

    localparam logic [31:0] GLIDER_R0 = 32'h0000_0002;
    localparam logic [31:0] GLIDER_R1 = 32'h0000_0004;
    localparam logic [31:0] GLIDER_R2 = 32'h0000_0007;

    function automatic logic [3:0] count_neighbours(input logic [7:0] nb);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(nb[i]);
        return n;
    endfunction
endpackage

// File: rtl/gol_row_next.sv
// gol_row_next: applies B3/S23 to one row given its vertical neighbours, columns wrapping toroidally.
module gol_row_next
    import gol_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] above,
    input  logic [W-1:0] cur,
    input  logic [W-1:0] below,
    output logic [W-1:0] nxt
);
    for (genvar c = 0; c < W; c++) begin : g_col
        localparam int L = (c + W - 1) % W;
        localparam int R = (c + 1) % W;
        logic [3:0] n;
        assign n = count_neighbours({above[L], above[c], above[R], cur[L], cur[R],
                                     below[L], below[c], below[R]});
        assign nxt[c] = (n == 4'd3) | (cur[c] & (n == 4'd2));
    end
endmodule

// File: rtl/gol_generation_engine.sv
// gol_generation_engine: double-buffered toroidal Game of Life grid, one row per cycle,
// with the displayed bank swapped in a single cycle so readers never see a mixed generation.
module gol_generation_engine
    import gol_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int ROW_AW = $clog2(GRID_H)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              wr_en,
    input  logic [ROW_AW-1:0] wr_row,
    input  logic [GRID_W-1:0] wr_data,
    input  logic [ROW_AW-1:0] rd_row,
    output logic [GRID_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       generation,
    output logic              extinct
);
    state_e state_q, state_d;
    logic [ROW_AW-1:0] row_q, row_d;
    logic [GRID_W-1:0] disp_q [GRID_H];
    logic [GRID_W-1:0] disp_d [GRID_H];
    logic [GRID_W-1:0] next_q [GRID_H];
    logic [GRID_W-1:0] next_d [GRID_H];
    logic [15:0] gen_q, gen_d;
    logic extinct_q, extinct_d;
    logic [GRID_W-1:0] above, cur, below, row_new;

    // Row selection by constant-index compare: out-of-range addresses simply match nothing.
    always_comb begin
        above = '0;
        cur = '0;
        below = '0;
        rd_data = '0;
        for (int i = 0; i < GRID_H; i++) begin
            if (row_q == ROW_AW'(i)) begin
                above = disp_q[(i + GRID_H - 1) % GRID_H];
                cur = disp_q[i];
                below = disp_q[(i + 1) % GRID_H];
            end
            if (rd_row == ROW_AW'(i)) rd_data = disp_q[i];
        end
    end

    gol_row_next #(.W(GRID_W)) u_row_next (
        .above(above),
        .cur(cur),
        .below(below),
        .nxt(row_new)
    );

    always_comb begin
        state_d = state_q;
        row_d = row_q;
        gen_d = gen_q;
        disp_d = disp_q;
        next_d = next_q;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < GRID_H; i++)
                    if (wr_en && wr_row == ROW_AW'(i)) disp_d[i] = wr_data;
                if (start && enable) begin
                    state_d = COMPUTE;
                    row_d = '0;
                end
            end
            COMPUTE: begin
                for (int i = 0; i < GRID_H; i++)
                    if (row_q == ROW_AW'(i)) next_d[i] = row_new;
                row_d = row_q + 1'b1;
                if (row_q == ROW_AW'(GRID_H - 1)) state_d = SWAP;
            end
            SWAP: begin
                disp_d = next_q;
                gen_d = gen_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        extinct_d = 1'b1;
        for (int i = 0; i < GRID_H; i++) extinct_d = extinct_d & (disp_d[i] == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q <= '0;
            gen_q <= '0;
            extinct_q <= 1'b0;
            for (int i = 0; i < GRID_H; i++) begin
                disp_q[i] <= (i == 0) ? GRID_W'(GLIDER_R0) :
                             (i == 1) ? GRID_W'(GLIDER_R1) :
                             (i == 2) ? GRID_W'(GLIDER_R2) : '0;
                next_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q <= row_d;
            gen_q <= gen_d;
            extinct_q <= extinct_d;
            disp_q <= disp_d;
            next_q <= next_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == SWAP;
    assign generation = gen_q;
    assign extinct = extinct_q;
endmodule

// File: tb/tb_gol_generation_engine.sv
// tb_gol_generation_engine: directed and random Game of Life runs checked against a cell-array model.
module tb_gol_generation_engine;
    localparam int W = 16;
    localparam int H = 16;

    logic clock = 1'b0;
    logic reset, enable, start, wr_en;
    logic [3:0] wr_row, rd_row;
    logic [15:0] wr_data, rd_data, generation;
    logic busy, done, extinct;

    int n_assert = 0;
    int fails = 0;
    bit m [H][W];
    int mgen;

    always #5 clock = ~clock;

    gol_generation_engine #(.GRID_W(W), .GRID_H(H)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .rd_row(rd_row),
        .rd_data(rd_data), .busy(busy), .done(done), .generation(generation),
        .extinct(extinct)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mrow(input int r);
        logic [15:0] v;
        for (int c = 0; c < W; c++) v[c] = m[r][c];
        return v;
    endfunction

    function automatic bit mzero();
        for (int r = 0; r < H; r++) if (mrow(r) != 16'h0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic mset(input int r, input logic [15:0] v);
        for (int c = 0; c < W; c++) m[r][c] = v[c];
    endtask

    task automatic mseed();
        for (int r = 0; r < H; r++) mset(r, 16'h0);
        mset(0, 16'h0002);
        mset(1, 16'h0004);
        mset(2, 16'h0007);
        mgen = 0;
    endtask

    task automatic mstep();
        bit t [H][W];
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) n += int'(m[(r + dr + H) % H][(c + dc + W) % W]);
                t[r][c] = (n == 3) || (m[r][c] && n == 2);
            end
        m = t;
        mgen = (mgen + 1) % 65536;
    endtask

    task automatic write_row(input int r, input logic [15:0] v);
        wr_en = 1'b1;
        wr_row = 4'(r);
        wr_data = v;
        @(negedge clock);
        wr_en = 1'b0;
        mset(r, v);
    endtask

    task automatic clear_grid();
        for (int r = 0; r < H; r++) write_row(r, 16'h0);
    endtask

    task automatic compare_all(input string tag);
        for (int r = 0; r < H; r++) begin
            rd_row = 4'(r);
            #1;
            check($sformatf("%s row%0d", tag, r), 32'(rd_data), 32'(mrow(r)));
            @(negedge clock);
        end
        check({tag, " generation"}, 32'(generation), 32'(mgen));
        check({tag, " extinct"}, 32'(extinct), 32'(mzero()));
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // One generation; optional row watch, mid-compute disturbance, or write coincident with start.
    task automatic run_gen(input int watch, input bit disturb, input bit cowr,
                           input int cr, input logic [15:0] cd);
        int cnt;
        logic [15:0] wv;
        start = 1'b1;
        if (cowr) begin
            wr_en = 1'b1;
            wr_row = 4'(cr);
            wr_data = cd;
            mset(cr, cd);
        end
        if (watch >= 0) rd_row = 4'(watch);
        wv = (watch >= 0) ? mrow(watch) : 16'h0;
        @(negedge clock);
        start = 1'b0;
        wr_en = 1'b0;
        cnt = 1;
        check("busy after start", 32'(busy), 32'd1);
        while (!done && cnt < 40) begin
            if (watch >= 0) check($sformatf("watch row%0d c%0d", watch, cnt), 32'(rd_data), 32'(wv));
            if (disturb && cnt == 5) begin
                start = 1'b1;
                wr_en = 1'b1;
                wr_row = 4'd3;
                wr_data = 16'hFFFF;
            end
            if (disturb && cnt == 6) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            if (disturb && cnt == 8) enable = 1'b0;
            @(negedge clock);
            cnt++;
        end
        check("done latency", 32'(cnt), 32'd17);
        mstep();
        @(negedge clock);
        enable = 1'b1;
        check("busy after done", 32'(busy), 32'd0);
        check("done one cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        enable = 1'b1;
        start = 1'b0;
        wr_en = 1'b0;
        wr_row = '0;
        wr_data = '0;
        rd_row = '0;
        mseed();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        compare_all("reset");

        run_gen(2, 1'b0, 1'b0, 0, 16'h0);
        repeat (3) run_gen(-1, 1'b0, 1'b0, 0, 16'h0);
        compare_all("glider4");
        rd_row = 4'd3;
        #1 check("glider4 row3 const", 32'(rd_data), 32'h000E);
        @(negedge clock);

        clear_grid();
        write_row(5, 16'h0070);
        run_gen(-1, 1'b0, 1'b0, 0, 16'h0);
        rd_row = 4'd4;
        #1 check("blinker row4 const", 32'(rd_data), 32'h0020);
        @(negedge clock);
        compare_all("blinker1");
        run_gen(-1, 1'b0, 1'b0, 0, 16'h0);
        compare_all("blinker2");

        clear_grid();
        write_row(0, 16'h8003);
        run_gen(-1, 1'b0, 1'b0, 0, 16'h0);
        rd_row = 4'd15;
        #1 check("torus row15 const", 32'(rd_data), 32'h0001);
        @(negedge clock);
        compare_all("torus");

        enable = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("disabled start busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        check("disabled start gen", 32'(generation), 32'(mgen));
        enable = 1'b1;

        clear_grid();
        write_row(5, 16'h0070);
        run_gen(-1, 1'b1, 1'b0, 0, 16'h0);
        repeat (20) @(negedge clock);
        compare_all("disturbed");

        clear_grid();
        run_gen(-1, 1'b0, 1'b1, 4, 16'h00E0);
        compare_all("cowrite fixed");
        run_gen(-1, 1'b0, 1'b1, 9, 16'($urandom));
        compare_all("cowrite random");

        clear_grid();
        write_row(7, 16'h0100);
        check("single cell extinct", 32'(extinct), 32'd0);
        run_gen(-1, 1'b0, 1'b0, 0, 16'h0);
        check("extinct const", 32'(extinct), 32'd1);
        compare_all("extinct");

        repeat (4) begin
            for (int r = 0; r < H; r++) write_row(r, 16'($urandom));
            k = int'($urandom_range(1, 3));
            repeat (k) run_gen(-1, 1'b0, 1'b0, 0, 16'h0);
            compare_all("random");
        end

        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        #1 check("reset abort busy", 32'(busy), 32'd0);
        check("reset abort gen", 32'(generation), 32'd0);
        rd_row = 4'd0;
        #1 check("reset abort row0", 32'(rd_data), 32'h0002);
        rd_row = 4'd1;
        #1 check("reset abort row1", 32'(rd_data), 32'h0004);
        rd_row = 4'd2;
        #1 check("reset abort row2", 32'(rd_data), 32'h0007);
        @(negedge clock);
        reset = 1'b0;
        mseed();
        @(negedge clock);
        compare_all("after abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, fails);
        $finish;
    end
endmodule
